// File: rtl/mem_port_arbiter.sv
// Arbitrates the single main-memory port between the I-cache fill path and the D-cache fill/write path.
// A read runs LATENCY wait cycles followed by a LINE_WORDS burst. A D-side store is a single-word write.
module mem_port_arbiter #(
    parameter int WORD_SIZE  = 16,
    parameter int LATENCY    = 4,
    parameter int LINE_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_req,
    input  logic [WORD_SIZE-1:0]          i_addr,
    input  logic                          d_req,
    input  logic                          d_we,
    input  logic [WORD_SIZE-1:0]          d_addr,
    input  logic [WORD_SIZE-1:0]          d_wdata,
    output logic                          mem_read,
    output logic                          mem_write,
    output logic [WORD_SIZE-1:0]          mem_addr,
    output logic [WORD_SIZE-1:0]          mem_wdata,
    input  logic [WORD_SIZE-1:0]          mem_rdata,
    output logic                          fill_valid,
    output logic                          fill_dst,
    output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
    output logic [WORD_SIZE-1:0]          fill_data,
    output logic                          i_done,
    output logic                          d_done,
    output logic                          busy
);
    localparam int IW = $clog2(LINE_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 we_q, we_d;
    logic                 last_q, last_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;

    logic                 grant_d_s;
    logic                 grant_i_s;
    logic [WORD_SIZE-1:0] req_addr_s;

    logic                 mem_read_d, mem_write_d;
    logic [WORD_SIZE-1:0] mem_addr_d, mem_wdata_d;
    logic                 fill_valid_d, fill_dst_d;
    logic [IW-1:0]        fill_idx_d;
    logic                 i_done_d, d_done_d, busy_d;

    // Owner/last-grant encoding: 0 = I side, 1 = D side. D wins a tie unless it won the previous grant.
    assign grant_d_s  = d_req && (!i_req || (last_q == 1'b0));
    assign grant_i_s  = i_req && !grant_d_s;
    assign req_addr_s = grant_d_s ? d_addr : i_addr;
    assign fill_data  = mem_rdata;

    // Next-state logic: arbitration, latency countdown and burst indexing.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_d_s || grant_i_s) begin
                    state_d = ST_WAIT;
                    owner_d = grant_d_s;
                    last_d  = grant_d_s;
                    we_d    = grant_d_s && d_we;
                    addr_d  = (grant_d_s && d_we) ? req_addr_s
                                                  : {req_addr_s[WORD_SIZE-1:IW], {IW{1'b0}}};
                    wdata_d = grant_d_s ? d_wdata : {WORD_SIZE{1'b0}};
                    cnt_d   = CW'(LATENCY - 1);
                    idx_d   = {IW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == {CW{1'b0}}) begin
                    if (we_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_BURST;
                        idx_d   = {IW{1'b0}};
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_BURST: begin
                // The index only ever wraps inside the line; the base keeps its cleared low bits.
                idx_d = idx_q + IW'(1);
                if (idx_q == IW'(LINE_WORDS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_BURST;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so every port can be driven from a flop.
    always_comb begin
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_addr_d   = {WORD_SIZE{1'b0}};
        mem_wdata_d  = {WORD_SIZE{1'b0}};
        fill_valid_d = 1'b0;
        fill_dst_d   = 1'b0;
        fill_idx_d   = {IW{1'b0}};
        i_done_d     = 1'b0;
        d_done_d     = 1'b0;
        busy_d       = (state_d != ST_IDLE);
        case (state_d)
            ST_WAIT: begin
                mem_addr_d = addr_d;
                if (we_d) begin
                    mem_write_d = 1'b1;
                    mem_wdata_d = wdata_d;
                end else begin
                    mem_read_d = 1'b1;
                end
            end
            ST_BURST: begin
                mem_read_d   = 1'b1;
                mem_addr_d   = {addr_d[WORD_SIZE-1:IW], idx_d};
                fill_valid_d = 1'b1;
                fill_dst_d   = owner_d;
                fill_idx_d   = idx_d;
            end
            ST_DONE: begin
                if (owner_d) begin
                    d_done_d = 1'b1;
                end else begin
                    i_done_d = 1'b1;
                end
            end
            ST_IDLE: begin
                busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Transaction state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            last_q  <= 1'b0;
            addr_q  <= {WORD_SIZE{1'b0}};
            wdata_q <= {WORD_SIZE{1'b0}};
            cnt_q   <= {CW{1'b0}};
            idx_q   <= {IW{1'b0}};
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Registered port outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= {WORD_SIZE{1'b0}};
            mem_wdata  <= {WORD_SIZE{1'b0}};
            fill_valid <= 1'b0;
            fill_dst   <= 1'b0;
            fill_idx   <= {IW{1'b0}};
            i_done     <= 1'b0;
            d_done     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            mem_read   <= mem_read_d;
            mem_write  <= mem_write_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            fill_valid <= fill_valid_d;
            fill_dst   <= fill_dst_d;
            fill_idx   <= fill_idx_d;
            i_done     <= i_done_d;
            d_done     <= d_done_d;
            busy       <= busy_d;
        end
    end

endmodule
